// File: rtl/predictor_pht_ctr_pkg.sv
// predictor_pht_ctr_pkg
// Shared definitions for the pattern-history-table counter block:
//   - default index and counter widths
//   - INIT/RUN state encoding
//   - weakly-not-taken initial value and saturating counter step
package predictor_pht_ctr_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_CTR_W  = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pht_state_e;

    // Weakly-not-taken: the value just below the taken threshold (MSB clear).
    function automatic int unsigned wnt_value(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    // Saturating step: never wraps at either end.
    function automatic int unsigned ctr_next(input int unsigned v,
                                             input logic        taken,
                                             input int unsigned ctr_w);
        int unsigned max_v;
        max_v = (32'd1 << ctr_w) - 32'd1;
        if (taken)
            return (v >= max_v) ? max_v : v + 32'd1;
        else
            return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/predictor_pht_ctr_if.sv
// predictor_pht_ctr_if
// Lookup / update / control bundle for predictor_pht_ctr.
//   flush_i                       restart table initialisation
//   ready_o                       table initialised, ports accepted
//   re_i, raddr_i                 lookup request
//   rvalid_o, rdata_o, taken_o    lookup response (one cycle later)
//   upd_valid_i, upd_addr_i,
//   upd_taken_i                   resolved-branch update
// master: requester side; slave: the table.
interface predictor_pht_ctr_if
    import predictor_pht_ctr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CTR_W  = DEF_CTR_W
);
    logic              flush_i;
    logic              ready_o;
    logic              re_i;
    logic [ADDR_W-1:0] raddr_i;
    logic              rvalid_o;
    logic [CTR_W-1:0]  rdata_o;
    logic              taken_o;
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_addr_i;
    logic              upd_taken_i;

    modport master (
        output flush_i, re_i, raddr_i, upd_valid_i, upd_addr_i, upd_taken_i,
        input  ready_o, rvalid_o, rdata_o, taken_o
    );

    modport slave (
        input  flush_i, re_i, raddr_i, upd_valid_i, upd_addr_i, upd_taken_i,
        output ready_o, rvalid_o, rdata_o, taken_o
    );
endinterface

// File: rtl/predictor_pht_ctr_mem.sv
// pht_ctr_mem
// Counter storage: 2^ADDR_W x CTR_W, two registered read ports and one
// write port.
//   clk, rst_n            clock, synchronous active-high reset (read regs only)
//   lk_re/lk_addr/lk_data lookup read port, data valid the cycle after lk_re
//   up_re/up_addr/up_data update read port, data valid the cycle after up_re
//   we/waddr/wdata        write port
// Read registers hold when their enable is low. A read and a write of the
// same entry in one cycle returns the pre-write value.
module pht_ctr_mem #(
    parameter int ADDR_W = 10,
    parameter int CTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lk_re,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic [CTR_W-1:0]  lk_data,
    input  logic              up_re,
    input  logic [ADDR_W-1:0] up_addr,
    output logic [CTR_W-1:0]  up_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CTR_W-1:0]  wdata
);
    logic [CTR_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            lk_data <= '0;
            up_data <= '0;
        end else begin
            if (lk_re)
                lk_data <= mem[lk_addr];
            if (up_re)
                up_data <= mem[up_addr];
        end
    end
endmodule

// File: rtl/predictor_pht_ctr.sv
// predictor_pht_ctr
// Branch pattern-history table of saturating counters.
//   clk    rising-edge clock
//   rst_n  synchronous reset, active HIGH (1 = reset) despite the name
//   bus    predictor_pht_ctr_if.slave (lookup, update, flush, ready)
// After reset or flush every entry is swept to weakly-not-taken, one entry
// per cycle. Updates are a two-stage read-modify-write (accept/read, then U1
// write); back-to-back updates to one index forward U1's result.
// Optional build macro PHT_WRITE_BYPASS_EN: a lookup colliding with the U1
// write committing in the same cycle returns the new value instead of the
// stale one.
module predictor_pht_ctr
    import predictor_pht_ctr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CTR_W  = DEF_CTR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    predictor_pht_ctr_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [CTR_W-1:0]  WNT      = CTR_W'(wnt_value(CTR_W));

    pht_state_e        state;
    logic [ADDR_W-1:0] sweep_idx;
    logic              ready_q;
    logic              rvalid_q;

    logic              u1_valid;
    logic [ADDR_W-1:0] u1_addr;
    logic              u1_taken;
    logic              u1_fwd;
    logic [CTR_W-1:0]  u1_fwd_val;
    logic [CTR_W-1:0]  u1_old;
    logic [CTR_W-1:0]  u1_new;

    logic              lk_hit;
    logic              lk_hit_q;
    logic [CTR_W-1:0]  lk_byp_q;

    logic              lk_acc;
    logic              upd_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [CTR_W-1:0]  mem_wdata;
    logic [CTR_W-1:0]  mem_lk_data;
    logic [CTR_W-1:0]  mem_up_data;

    assign lk_acc  = !rst_n && !bus.flush_i && (state == ST_RUN) && bus.re_i;
    assign upd_acc = !rst_n && !bus.flush_i && (state == ST_RUN) && bus.upd_valid_i;

    // Memory still holds the pre-write value when the previous update
    // targeted the same index; take U1's result in that case.
    assign u1_old = u1_fwd ? u1_fwd_val : mem_up_data;
    assign u1_new = CTR_W'(ctr_next(32'(u1_old), u1_taken, CTR_W));

`ifdef PHT_WRITE_BYPASS_EN
    assign lk_hit = u1_valid && (u1_addr == bus.raddr_i);
`else
    assign lk_hit = 1'b0;
`endif

    // Sweep owns the write port in INIT; U1 only exists in RUN. A flush
    // drops the U1 write of that cycle.
    assign mem_we    = !rst_n && ((state == ST_INIT) || (u1_valid && !bus.flush_i));
    assign mem_waddr = (state == ST_INIT) ? sweep_idx : u1_addr;
    assign mem_wdata = (state == ST_INIT) ? WNT : u1_new;

    pht_ctr_mem #(.ADDR_W(ADDR_W), .CTR_W(CTR_W)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .lk_re   (lk_acc),
        .lk_addr (bus.raddr_i),
        .lk_data (mem_lk_data),
        .up_re   (upd_acc),
        .up_addr (bus.upd_addr_i),
        .up_data (mem_up_data),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst_n || bus.flush_i) begin
            state      <= ST_INIT;
            sweep_idx  <= '0;
            ready_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            u1_valid   <= 1'b0;
            u1_fwd     <= 1'b0;
            if (rst_n) begin
                u1_addr    <= '0;
                u1_taken   <= 1'b0;
                u1_fwd_val <= '0;
                lk_hit_q   <= 1'b0;
                lk_byp_q   <= '0;
            end
        end else begin
            case (state)
                ST_INIT: begin
                    rvalid_q  <= 1'b0;
                    u1_valid  <= 1'b0;
                    sweep_idx <= sweep_idx + ADDR_W'(1);
                    if (sweep_idx == LAST_IDX) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    rvalid_q <= bus.re_i;
                    if (bus.re_i) begin
                        lk_hit_q <= lk_hit;
                        lk_byp_q <= u1_new;
                    end
                    u1_valid <= bus.upd_valid_i;
                    if (bus.upd_valid_i) begin
                        u1_addr    <= bus.upd_addr_i;
                        u1_taken   <= bus.upd_taken_i;
                        u1_fwd     <= u1_valid && (u1_addr == bus.upd_addr_i);
                        u1_fwd_val <= u1_new;
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    sweep_idx <= '0;
                end
            endcase
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = lk_hit_q ? lk_byp_q : mem_lk_data;
    assign bus.taken_o  = bus.rdata_o[CTR_W-1];
endmodule

// File: tb/tb_predictor_pht_ctr.sv
// tb_predictor_pht_ctr
// Directed bench for predictor_pht_ctr at ADDR_W=4, CTR_W=2.
// Define PHT_WRITE_BYPASS_EN to build the bypass variant of the same
// scenario set.
module tb_predictor_pht_ctr;
    localparam int AW = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    predictor_pht_ctr_if #(.ADDR_W(AW), .CTR_W(CW)) bus ();

    predictor_pht_ctr #(.ADDR_W(AW), .CTR_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic lookup(input int addr, input int exp, input string tag);
        bus.re_i    = 1'b1;
        bus.raddr_i = AW'(addr);
        tick();
        bus.re_i    = 1'b0;
        chk({tag, "_rvalid"}, int'(bus.rvalid_o), 1);
        chk({tag, "_rdata"},  int'(bus.rdata_o), exp);
        chk({tag, "_taken"},  int'(bus.taken_o), (exp >> 1) & 1);
    endtask

    task automatic update(input int addr, input logic tk);
        bus.upd_valid_i = 1'b1;
        bus.upd_addr_i  = AW'(addr);
        bus.upd_taken_i = tk;
        tick();
        bus.upd_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Counts cycles until ready_o rises; rvalid_o must stay low throughout.
    task automatic count_sweep(input string tag, output int n);
        n = 0;
        while (!bus.ready_o && n < 64) begin
            chk({tag, "_rvalid_low"}, int'(bus.rvalid_o), 0);
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int bypass_exp;

        bus.flush_i     = 1'b0;
        bus.re_i        = 1'b0;
        bus.raddr_i     = '0;
        bus.upd_valid_i = 1'b0;
        bus.upd_addr_i  = '0;
        bus.upd_taken_i = 1'b0;
        rst_n           = 1'b1;

        idle(3);
        chk("rst_ready",  int'(bus.ready_o), 0);
        chk("rst_rvalid", int'(bus.rvalid_o), 0);
        chk("rst_rdata",  int'(bus.rdata_o), 0);
        chk("rst_taken",  int'(bus.taken_o), 0);

        // Initial sweep: lookups issued during INIT must be ignored.
        rst_n       = 1'b0;
        bus.re_i    = 1'b1;
        bus.raddr_i = 4'd3;
        count_sweep("init", n);
        bus.re_i    = 1'b0;
        chk("init_sweep_len", n, 16);

        for (int i = 0; i < 16; i++) lookup(i, 1, "init_entry");

        // rdata_o holds after a lookup when no new request arrives.
        idle(1);
        chk("hold_rvalid", int'(bus.rvalid_o), 0);
        chk("hold_rdata",  int'(bus.rdata_o), 1);

        // Spaced updates to index 5: 01 -> 10 -> 11 -> 11 (saturate).
        for (int i = 0; i < 3; i++) begin
            update(5, 1'b1);
            idle(2);
        end
        lookup(5, 3, "idx5_sat_hi");
        update(5, 1'b0);
        idle(2);
        update(5, 1'b0);
        idle(2);
        lookup(5, 1, "idx5_down");
        update(5, 1'b0);
        idle(2);
        update(5, 1'b0);
        idle(2);
        lookup(5, 0, "idx5_sat_lo");

        // Back-to-back updates to index 3 chain through the U1 forward.
        update(3, 1'b1);
        update(3, 1'b1);
        update(3, 1'b1);
        idle(2);
        lookup(3, 3, "idx3_chain");

        // Lookup of index 7 in the cycle its U1 write (01 -> 10) commits.
`ifdef PHT_WRITE_BYPASS_EN
        bypass_exp = 2;
`else
        bypass_exp = 1;
`endif
        update(7, 1'b1);
        lookup(7, bypass_exp, "idx7_collide");
        lookup(7, 2, "idx7_after");

        // Flush with an update to index 9 in flight.
        update(9, 1'b1);
        idle(2);
        lookup(9, 2, "idx9_pre");
        update(9, 1'b1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        chk("flush_ready", int'(bus.ready_o), 0);
        bus.re_i    = 1'b1;
        bus.raddr_i = 4'd9;
        count_sweep("flush", n);
        bus.re_i    = 1'b0;
        chk("flush_sweep_len", n, 16);
        chk("flush_rvalid_end", int'(bus.rvalid_o), 0);
        lookup(9, 1, "idx9_post");

        // Updates to index 2, then reset 8 cycles into a sweep.
        update(2, 1'b1);
        idle(2);
        update(2, 1'b1);
        idle(2);
        lookup(2, 3, "idx2_pre");
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("midsweep_ready", int'(bus.ready_o), 0);
            tick();
        end
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk("midsweep_rst_ready", int'(bus.ready_o), 0);
        count_sweep("resweep", n);
        chk("resweep_len", n, 16);
        lookup(2, 1, "idx2_post");

        // Reset and flush together behave as reset.
        update(4, 1'b1);
        idle(2);
        rst_n       = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        rst_n       = 1'b0;
        bus.flush_i = 1'b0;
        chk("rstflush_rdata", int'(bus.rdata_o), 0);
        count_sweep("rstflush", n);
        chk("rstflush_len", n, 16);
        lookup(4, 1, "idx4_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/predictor_pht_ctr.md
PREDICTOR_PHT_CTR -- requirements
Module: predictor_pht_ctr

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning index width; depth = 2^ADDR_W entries.
REQ-002 SHALL have parameter CTR_W, default 2, meaning saturating-counter width (legal range 2..4).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous reset, active-high (1 = reset).
REQ-005 SHALL have port flush_i  in  1  restart the table-initialisation sweep.
REQ-006 SHALL have port ready_o  out  1  table initialised; read and update ports accepted.
REQ-007 SHALL have port re_i  in  1  lookup request.
REQ-008 SHALL have port raddr_i  in  ADDR_W  lookup index.
REQ-009 SHALL have port rvalid_o  out  1  rdata_o valid this cycle.
REQ-010 SHALL have port rdata_o  out  CTR_W  counter value.
REQ-011 SHALL have port taken_o  out  1  prediction = rdata_o MSB.
REQ-012 SHALL have port upd_valid_i  in  1  resolved-branch update.
REQ-013 SHALL have port upd_addr_i  in  ADDR_W  update index.
REQ-014 SHALL have port upd_taken_i  in  1  resolved direction.

Function
REQ-015 SHALL implement FSM states INIT and RUN; reset or flush_i enters INIT with sweep index 0.
REQ-016 In INIT, SHALL write WNT = 2^(CTR_W-1)-1 to one entry per cycle at ascending index, and enter RUN after writing index 2^ADDR_W-1.
REQ-017 ready_o SHALL be 1 only in RUN; in INIT, re_i and upd_valid_i SHALL be ignored and rvalid_o held 0.
REQ-018 A lookup accepted in cycle T SHALL drive rvalid_o=1 and rdata_o in cycle T+1; otherwise rvalid_o SHALL be 0 and rdata_o SHALL hold its last value.
REQ-019 Each update SHALL be an internal read-modify-write: accepted in T, read in T, written at the end of T+1.
REQ-020 Counter arithmetic: taken increments, saturating at 2^CTR_W-1; not-taken decrements, saturating at 0; no wrap-around.
REQ-021 Back-to-back updates to the same index SHALL chain: the second update SHALL use the first update's new value, forwarded from stage U1.
REQ-022 flush_i in RUN SHALL discard any in-flight update and any pending lookup response.
REQ-023 If flush_i and reset coincide, reset SHALL take priority; the outcome is identical.

Reset
REQ-024 On reset: ready_o=0, rvalid_o=0, rdata_o=0, taken_o=0, sweep index 0, U1 stage invalid.
REQ-025 Reset asserted mid-sweep or mid-update SHALL abandon that work and restart the full sweep.

Configuration
REQ-026 Macro PHT_WRITE_BYPASS_EN defined: a lookup in cycle T whose index matches the U1 write committing at the end of T SHALL return the newly written value.
REQ-027 Macro PHT_WRITE_BYPASS_EN undefined: that lookup SHALL return the pre-write (stale) value; all other behaviour is unchanged.

Structure
REQ-028 The shared define header SHALL hold the default ADDR_W/CTR_W, the INIT/RUN state encodings, and the WNT-value expression.
REQ-029 Storage SHALL be one sub-module, pht_ctr_mem: 2^ADDR_W x CTR_W, two synchronous read ports (lookup, update), one write port (sweep or U1, mutually exclusive by state).

Verification (ADDR_W=4, CTR_W=2)
REQ-030 Release reset -> ready_o=0 for exactly 16 cycles, then 1; a lookup of every index returns 2'b01.
REQ-031 Three taken updates to index 5, spaced 3 cycles apart, then lookup 5 -> rdata_o 2'b11, taken_o=1; two further not-taken updates -> 2'b01.
REQ-032 Back-to-back taken updates to index 3 on consecutive cycles (x3) -> index 3 reads 2'b11, not 2'b10.
REQ-033 Lookup of index 7 in the cycle its U1 write (01->10) commits -> 2'b10 with PHT_WRITE_BYPASS_EN, 2'b01 without.
REQ-034 Reset pulse 8 cycles into the sweep, following updates to index 2 -> ready_o low for 16 further cycles; index 2 reads 2'b01.
REQ-035 flush_i with an update in flight to index 9 -> 16-cycle sweep; index 9 reads 2'b01; no rvalid_o during the sweep.
